// File: rtl/map_ctrl_pkg.sv
// Shared types and constants for the ball stepping controller.
// Wrap-around at grid edges is enabled by defining BALL_WRAP_EN.
package map_ctrl_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FETCH,
    S_WAIT,
    S_DECIDE
  } step_state_t;

  localparam int MAP_W = 160;
  localparam int MAP_H = 90;

  localparam logic [3:0] WALL = 4'd1;
  localparam logic [3:0] GOAL = 4'd2;

endpackage

// File: rtl/ball_step_calc.sv
// Target tile from position and heading; flags off-grid targets.
// BALL_WRAP_EN turns grid edges into wrap-around instead of walls.
module ball_step_calc
  import map_ctrl_pkg::*;
#(
  parameter int WIDTH  = MAP_W,
  parameter int HEIGHT = MAP_H
) (
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  dir_t       dir_in,
  output logic [7:0] tx_out,
  output logic [6:0] ty_out,
  output logic       off_grid_out
);

`ifdef BALL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [7:0] XMAX = 8'(WIDTH - 1);
  localparam logic [6:0] YMAX = 7'(HEIGHT - 1);

  always_comb begin
    tx_out       = x_in;
    ty_out       = y_in;
    off_grid_out = 1'b0;
    unique case (dir_in)
      UP: begin
        if (y_in == 7'd0) begin
          if (WRAP) ty_out = YMAX;
          else      off_grid_out = 1'b1;
        end else begin
          ty_out = y_in - 7'd1;
        end
      end
      DOWN: begin
        if (y_in == YMAX) begin
          if (WRAP) ty_out = 7'd0;
          else      off_grid_out = 1'b1;
        end else begin
          ty_out = y_in + 7'd1;
        end
      end
      LEFT: begin
        if (x_in == 8'd0) begin
          if (WRAP) tx_out = XMAX;
          else      off_grid_out = 1'b1;
        end else begin
          tx_out = x_in - 8'd1;
        end
      end
      RIGHT: begin
        if (x_in == XMAX) begin
          if (WRAP) tx_out = 8'd0;
          else      off_grid_out = 1'b1;
        end else begin
          tx_out = x_in + 8'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/ball_step_ctrl.sv
// Steps the ball one tile per STEP_FRAMES frames, checking the map BRAM.
// Edge behaviour selected by BALL_WRAP_EN (see ball_step_calc).
module ball_step_ctrl
  import map_ctrl_pkg::*;
#(
  parameter int         WIDTH       = MAP_W,
  parameter int         HEIGHT      = MAP_H,
  parameter int         START_X     = 4,
  parameter int         START_Y     = 4,
  parameter int         STEP_FRAMES = 4,
  parameter int         RD_LATENCY  = 2,
  parameter logic [3:0] WALL_TILE   = WALL,
  parameter logic [3:0] GOAL_TILE   = GOAL
) (
  input  logic                               pixel_clk_in,
  input  logic                               rst_in,
  input  logic                               new_frame_in,
  input  logic                               restart_in,
  input  logic                               dir_valid_in,
  input  logic [1:0]                         dir_in,
  output logic                               dir_ready_out,
  output logic                               tile_rd_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    tile_addr_out,
  input  logic [3:0]                         tile_data_in,
  output logic [7:0]                         ballx_out,
  output logic [6:0]                         bally_out,
  output logic                               moving_out,
  output logic                               goal_out
);

  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(STEP_FRAMES - 1);
  localparam logic [7:0] W_LAST = 8'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
  localparam logic [7:0] X0 = 8'(START_X);
  localparam logic [6:0] Y0 = 7'(START_Y);

  step_state_t   state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          due_q, due_d;
  dir_t          head_q, head_d;
  logic          mv_q, mv_d;
  logic          goal_q, goal_d;
  logic [7:0]    x_q, x_d, tx_q, tx_d, tx_c;
  logic [6:0]    y_q, y_d, ty_q, ty_d, ty_c;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          off_c;
  logic          wrap_c;

  ball_step_calc #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_calc (
    .x_in         (x_q),
    .y_in         (y_q),
    .dir_in       (head_q),
    .tx_out       (tx_c),
    .ty_out       (ty_c),
    .off_grid_out (off_c)
  );

  assign dir_ready_out = (state_q == S_IDLE) && !goal_q;
  assign wrap_c        = new_frame_in && (fcnt_q == F_LAST);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    due_d   = due_q;
    head_d  = head_q;
    mv_d    = mv_q;
    goal_d  = goal_q;
    x_d     = x_q;
    y_d     = y_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    wcnt_d  = wcnt_q;

    if (new_frame_in) fcnt_d = wrap_c ? '0 : fcnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (dir_valid_in && dir_ready_out) begin
          head_d = dir_t'(dir_in);
          mv_d   = 1'b1;
        end
        if (due_q) begin
          due_d = 1'b0;
          if (mv_q && !goal_q) state_d = S_CALC;
        end
      end
      S_CALC: begin
        tx_d = tx_c;
        ty_d = ty_c;
        if (off_c) begin
          mv_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          addr_d  = AW'(tx_c) + AW'(ty_c) * AW'(WIDTH);
          rd_d    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        wcnt_d  = '0;
        state_d = (RD_LATENCY == 1) ? S_DECIDE : S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == W_LAST) state_d = S_DECIDE;
        else                  wcnt_d  = wcnt_q + 8'd1;
      end
      S_DECIDE: begin
        state_d = S_IDLE;
        if (tile_data_in == WALL_TILE) begin
          mv_d = 1'b0;
        end else begin
          x_d = tx_q;
          y_d = ty_q;
          if (tile_data_in == GOAL_TILE) begin
            goal_d = 1'b1;
            mv_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A frame wrap on the same cycle as the IDLE clear must not be lost
    if (wrap_c) due_d = 1'b1;

    if (restart_in) begin
      state_d = S_IDLE;
      fcnt_d  = '0;
      due_d   = 1'b0;
      head_d  = UP;
      mv_d    = 1'b0;
      goal_d  = 1'b0;
      x_d     = X0;
      y_d     = Y0;
      tx_d    = '0;
      ty_d    = '0;
      addr_d  = '0;
      rd_d    = 1'b0;
      wcnt_d  = '0;
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      due_q   <= 1'b0;
      head_q  <= UP;
      mv_q    <= 1'b0;
      goal_q  <= 1'b0;
      x_q     <= X0;
      y_q     <= Y0;
      tx_q    <= '0;
      ty_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      due_q   <= due_d;
      head_q  <= head_d;
      mv_q    <= mv_d;
      goal_q  <= goal_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign tile_rd_out   = rd_q;
  assign tile_addr_out = addr_q;
  assign ballx_out     = x_q;
  assign bally_out     = y_q;
  assign moving_out    = mv_q;
  assign goal_out      = goal_q;

endmodule

// File: tb/tb_ball_step_ctrl.sv
// Scoreboard bench for ball_step_ctrl: map model, read-address queue,
// and a reference ball model stepped on every frame pulse.
module tb_ball_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nf = 1'b0;
  logic        rs = 1'b0;
  logic        dv = 1'b0;
  logic [1:0]  dir = 2'd0;
  logic        rdy;
  logic        trd;
  logic [13:0] taddr;
  logic [3:0]  tdata;
  logic [7:0]  bx;
  logic [6:0]  by;
  logic        mv;
  logic        gl;

  always #5 clk = ~clk;

  ball_step_ctrl dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst),
    .new_frame_in  (nf),
    .restart_in    (rs),
    .dir_valid_in  (dv),
    .dir_in        (dir),
    .dir_ready_out (rdy),
    .tile_rd_out   (trd),
    .tile_addr_out (taddr),
    .tile_data_in  (tdata),
    .ballx_out     (bx),
    .bally_out     (by),
    .moving_out    (mv),
    .goal_out      (gl)
  );

  logic [3:0]  tmap [0:14399];
  logic [13:0] a0 = '0, a1 = '0;
  logic        v0 = 1'b0, v1 = 1'b0;

  always @(posedge clk) begin
    v0 <= trd;
    a0 <= taddr;
    v1 <= v0;
    a1 <= a0;
  end

  assign tdata = v1 ? tmap[a1] : 4'hF;

  int nvec = 0;
  int nerr = 0;
  int rdq[$];

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && trd) begin
      if (rdq.size() == 0) chk("rd_unexp", int'(trd), 0);
      else chk("rd_addr", int'(taddr), rdq.pop_front());
    end
  end

  int mx, my, mhead, fcnt;
  bit mmv, mgoal;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    mx = 4; my = 4; mmv = 0; mgoal = 0; fcnt = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_x"}, int'(bx), mx);
    chk({tag, "_y"}, int'(by), my);
    chk({tag, "_mv"}, int'(mv), int'(mmv));
    chk({tag, "_goal"}, int'(gl), int'(mgoal));
    chk({tag, "_rdy"}, int'(rdy), int'(!mgoal));
  endtask

  task automatic send_dir(input int d);
    int n = 0;
    while (!rdy && n < 20) begin
      tick;
      n++;
    end
    if (!rdy) begin
      chk("rdy_to", int'(rdy), 1);
    end else begin
      dv = 1'b1;
      dir = 2'(d);
      tick;
      dv = 1'b0;
      mhead = d;
      mmv = 1;
    end
  endtask

  task automatic frame(input bit abort);
    int ox, oy, tx, ty, a;
    bit rd, off;
    ox = mx; oy = my; rd = 0; off = 0;
    fcnt = (fcnt + 1) % 4;
    if (fcnt == 0 && mmv && !mgoal) begin
      tx = mx + ((mhead == 3) ? 1 : (mhead == 2) ? -1 : 0);
      ty = my + ((mhead == 1) ? 1 : (mhead == 0) ? -1 : 0);
`ifdef BALL_WRAP_EN
      tx = (tx + 160) % 160;
      ty = (ty + 90) % 90;
`else
      off = (tx < 0) || (tx > 159) || (ty < 0) || (ty > 89);
`endif
      if (off) begin
        mmv = 0;
      end else begin
        rd = 1;
        a = tx + ty * 160;
        rdq.push_back(a);
        if (!abort) begin
          if (tmap[a] == 4'd1) begin
            mmv = 0;
          end else begin
            mx = tx; my = ty;
            if (tmap[a] == 4'd2) begin
              mgoal = 1; mmv = 0;
            end
          end
        end
      end
    end
    nf = 1'b1;
    tick;
    nf = 1'b0;
    if (abort) begin
      repeat (3) tick;
      rs = 1'b1;
      tick;
      rs = 1'b0;
      model_reset();
      repeat (6) tick;
    end else begin
      for (int k = 0; k < 7; k++) begin
        tick;
        if (rd && k == 3) begin
          chk("pre_x", int'(bx), ox);
          chk("pre_y", int'(by), oy);
        end
        if (rd && k == 4) begin
          chk("post_x", int'(bx), mx);
          chk("post_y", int'(by), my);
        end
      end
    end
    check_state("frm");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog nvec %0d exp finish", nvec);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 14400; i++) tmap[i] = 4'd0;
    tmap[647] = 4'd1;
    tmap[806] = 4'd2;
    model_reset();
    mhead = 0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check_state("rst");
    chk("rst_rd", int'(trd), 0);
    chk("rst_addr", int'(taddr), 0);

    send_dir(3);
    repeat (8) frame(0);

    repeat (4) frame(0);
    repeat (8) frame(0);

    send_dir(1);
    repeat (4) frame(0);
    repeat (8) frame(0);

    rs = 1'b1;
    tick;
    rs = 1'b0;
    model_reset();
    tick;
    check_state("restart");

    send_dir(3);
    repeat (3) frame(0);
    frame(1);
    repeat (4) tick;
    check_state("abort");

    send_dir(1);
    repeat (24) frame(0);
    send_dir(3);
    repeat (620) frame(0);
    chk("edge_x", int'(bx), 159);
    chk("edge_y", int'(by), 10);
    repeat (4) frame(0);
    repeat (4) tick;
    chk("rdq_empty", rdq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ball_step_ctrl.md
# ball_step_ctrl

Moves the ball across the 160x90 tile map, one tile at a time, and drives the `ballx`/`bally` inputs of the map renderer. On a fixed frame cadence it reads the target tile through a read port of the shared map BRAM. It then commits the move, blocks it on a wall, or latches a goal. All updates happen during vblank, so the renderer never sees a mid-frame position change.

## Interface
Parameters:
- `WIDTH`, 160, map width in tiles
- `HEIGHT`, 90, map height in tiles
- `START_X`, 4, reset/restart tile column
- `START_Y`, 4, reset/restart tile row
- `STEP_FRAMES`, 4, frames per step attempt (≥1)
- `RD_LATENCY`, 2, map BRAM read latency in cycles (≥1; 2 for HIGH_PERFORMANCE)
- `WALL_TILE`, 4'd1, tile code that blocks movement
- `GOAL_TILE`, 4'd2, tile code that ends the run

Ports:
- `pixel_clk_in` in 1: sole clock
- `rst_in` in 1: reset, asynchronous, active-high
- `new_frame_in` in 1: one-cycle pulse at vblank start
- `restart_in` in 1: synchronous restart
- `dir_valid_in` in 1: direction offered
- `dir_in` in 2: 00 up, 01 down, 10 left, 11 right
- `dir_ready_out` out 1: direction accepted when valid&ready
- `tile_rd_out` out 1: one-cycle map read strobe
- `tile_addr_out` out $clog2(WIDTH*HEIGHT) (14): tile address x + y*WIDTH
- `tile_data_in` in 4: map tile code
- `ballx_out` out 8: ball tile column
- `bally_out` out 7: ball tile row
- `moving_out` out 1: heading active
- `goal_out` out 1: goal reached (sticky)

## Operation
- Reset values: `ballx_out`=START_X, `bally_out`=START_Y, `moving_out`=0, `goal_out`=0, `tile_rd_out`=0, `tile_addr_out`=0, `dir_ready_out`=1. Internal state: IDLE, frame counter 0, step_due 0.
- Direction handshake:
  - `dir_ready_out`=1 only in IDLE and only while `goal_out`=0.
  - On accept, the heading register is loaded and `moving_out` is set to 1.
  - A later accept overwrites the heading.
- Frame counter:
  - Increments on each `new_frame_in`, in any state.
  - When it wraps from STEP_FRAMES-1 to 0, step_due is set.
- FSM states: IDLE, CALC, FETCH, WAIT, DECIDE.
  - IDLE→CALC when step_due&moving&!goal; step_due is cleared. If step_due is set but the ball is not moving, step_due is just cleared.
  - CALC computes the target tile (tx,ty). If the target is off-grid and wrap is not enabled: clear `moving_out`, go to IDLE, issue no read. Otherwise go to FETCH.
  - FETCH drives `tile_rd_out`=1 for this one cycle only. `tile_addr_out`=tx+ty*WIDTH, held unchanged until DECIDE exits. Next state is WAIT, or DECIDE directly if RD_LATENCY=1.
  - WAIT lasts RD_LATENCY-1 cycles.
  - DECIDE samples `tile_data_in`:
    - WALL_TILE → position unchanged, `moving_out`←0.
    - GOAL_TILE → position←target, `goal_out`←1, `moving_out`←0.
    - Any other code → position←target.
    - Always returns to IDLE.
- `restart_in` has top priority in every state. It forces the reset values, except that `rst_in` remains the only asynchronous path. Any in-flight read is abandoned and its data is ignored.
- Simultaneous `restart_in` and dir accept: restart wins, the direction is dropped.
- Width rule: address product computed at 14 bits, with no truncation for x≤159, y≤89.

## Timing
- Trigger cycle T is the IDLE cycle with step_due set.
  - CALC at T+1, FETCH at T+2.
  - DECIDE at T+2+RD_LATENCY.
  - New position visible at T+3+RD_LATENCY (T+5 at default).
- `tile_data_in` is valid exactly RD_LATENCY cycles after the `tile_rd_out` cycle.
- Outputs are registered. `ballx_out`/`bally_out` change only on the DECIDE→IDLE edge.

## Configuration
- `BALL_WRAP_EN` defined: grid edges wrap.
  - x: 159+1→0 and 0-1→159.
  - y: 89+1→0 and 0-1→89.
  - A read is always issued.
- `BALL_WRAP_EN` undefined: an off-grid target acts as a wall. `moving_out` clears in CALC and no `tile_rd_out` is issued.

## Structure
- Package `map_ctrl_pkg`: `dir_t` enum (UP, DOWN, LEFT, RIGHT), `step_state_t` enum, MAP_W/MAP_H constants, WALL/GOAL tile codes.
- Sub-module `ball_step_calc`: combinational (x,y,dir) → (tx,ty,off_grid). It is the only place `BALL_WRAP_EN` is tested.

## Test plan
- Reset: release `rst_in` → `ballx_out`=4, `bally_out`=4, `moving_out`=0, `goal_out`=0, `dir_ready_out`=1, `tile_rd_out`=0.
- Free move: accept dir=11, then 4 `new_frame_in` pulses, map returns 0 → single `tile_rd_out` with addr 645. `ballx_out`=5 at T+5; next step reads addr 646.
- Wall: target tile returns 1 → position stays (4,4), `moving_out`=0, no further reads until a new direction is accepted.
- Edge: ball at (159,10) heading right.
  - Without `BALL_WRAP_EN`: no `tile_rd_out`, `moving_out`=0.
  - With `BALL_WRAP_EN`: addr 1600, `ballx_out`=0.
- Goal: tile returns 2 → ball moves, `goal_out`=1, `dir_ready_out`=0, no reads on later frames. `restart_in` → (4,4), `goal_out`=0.
- Restart mid-read: `restart_in` asserted during WAIT, with tile data 0 arriving the next cycle → no position change, FSM returns to IDLE, late data is ignored.
